// File: rtl/board_link_pkg.sv
// -----------------------------------------------------------------------------
// board_link_pkg
//
// Definitions shared by the board-state link transmitter and receiver:
//   - link_state_t : receiver/transmitter frame state
//   - BOARD_PKT_LEN : payload bits in one board packet (9x9 cells x 2 bits)
//   - DEF_*        : default timing for the 65 MHz / 9600 baud link
//   - START_LVL, STOP_LVL, IDLE_LVL : line levels of the frame format
//   - maj3()       : 2-of-3 vote used by the oversampling receiver
// -----------------------------------------------------------------------------
package board_link_pkg;

  // One board: 9 x 9 cells, 2 bits per cell, flattened.
  localparam int BOARD_PKT_LEN = 162;

  // Default link timing.
  localparam int DEF_CLK_HZ        = 65_000_000;
  localparam int DEF_BAUD_RATE     = 9600;
  localparam int DEF_SAMP_PER_BIT  = 16;
  localparam int DEF_WAITING_COUNT = 130_000;

  // Frame format: a low start bit, payload LSB first, a high stop bit.
  // The line rests high between frames.
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } link_state_t;

  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/samp_tick_gen.sv
// -----------------------------------------------------------------------------
// samp_tick_gen
//
// Oversampling timebase for the board-link receiver.
//   - samp_cnt runs 0..CLK_PER_SAMP-1; tick is high on its last count.
//   - samp_idx counts ticks within one bit, 0..SAMP_PER_BIT-1, wrapping.
//   - rx_s is captured at the ticks with samp_idx = M-1, M, M+1
//     (M = SAMP_PER_BIT/2); vote is the 2-of-3 majority of those samples.
//
// Ports:
//   clk_in   in   system clock
//   rst_in   in   synchronous active-high reset
//   clear    in   hold samp_cnt and samp_idx at 0 (start-bit alignment)
//   rx_s     in   synchronized serial line
//   tick     out  one-cycle sample strobe
//   samp_idx out  index of the current sample within the bit
//   vote     out  majority decision, valid at ticks with samp_idx >= M+1
// -----------------------------------------------------------------------------
module samp_tick_gen
  import board_link_pkg::*;
#(
  parameter int CLK_PER_SAMP = 423,
  parameter int SAMP_PER_BIT = 16,
  parameter int IDX_W        = $clog2(SAMP_PER_BIT)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             rx_s,
  output logic             tick,
  output logic [IDX_W-1:0] samp_idx,
  output logic             vote
);

  localparam int CNT_W = $clog2(CLK_PER_SAMP);
  localparam int M     = SAMP_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SAMP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMP_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(M - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(M);
  localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(M + 1);

  logic [CNT_W-1:0] samp_cnt;
  logic             samp_lo;
  logic             samp_mid;
  logic             samp_hi;

  assign tick = (samp_cnt == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      samp_cnt <= '0;
      samp_idx <= '0;
    end else if (tick) begin
      samp_cnt <= '0;
      samp_idx <= (samp_idx == IDX_LAST) ? '0 : samp_idx + 1'b1;
    end else begin
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      samp_lo  <= IDLE_LVL;
      samp_mid <= IDLE_LVL;
      samp_hi  <= IDLE_LVL;
    end else if (tick) begin
      if (samp_idx == IDX_LO)  samp_lo  <= rx_s;
      if (samp_idx == IDX_MID) samp_mid <= rx_s;
      if (samp_idx == IDX_HI)  samp_hi  <= rx_s;
    end
  end

  // On the M+1 tick itself the third sample is still on the wire, so the
  // vote takes it live. With SAMP_PER_BIT = 4 that tick is also the bit's
  // last tick, where the decision is consumed.
  assign vote = maj3(samp_lo, samp_mid, (samp_idx == IDX_HI) ? rx_s : samp_hi);

endmodule

// File: rtl/board_pkt_rx.sv
// -----------------------------------------------------------------------------
// board_pkt_rx
//
// Serial receiver for the board-state link. Recovers one PKT_LEN-bit packet
// framed as: start bit (0), PKT_LEN data bits LSB first, stop bit (1). Each
// bit is oversampled SAMP_PER_BIT times and decided by a 3-sample majority
// around mid-bit. After every frame (good or bad) the line must stay high
// for WAITING_COUNT consecutive clocks before a new start bit is accepted.
//
// Ports:
//   clk_in    in   system clock (65 MHz nominal)
//   rst_in    in   synchronous active-high reset
//   rx        in   asynchronous serial line, idles high
//   ready     out  one-cycle pulse: a new good packet is on data_out
//   frame_err out  one-cycle pulse: packet dropped because of a bad stop bit
//   data_out  out  last good packet; bit 0 is the first payload bit received
//
// Output handshake: ready and frame_err are pure strobes with no
// back-pressure. The consumer samples data_out in the cycle ready is high
// (or any later cycle before the next ready); the two strobes are never
// high together and each lasts exactly one cycle.
//
// The frame FSM lives in `state` (link_state_t) for probing.
// -----------------------------------------------------------------------------
module board_pkt_rx
  import board_link_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int BAUD_RATE     = DEF_BAUD_RATE,
  parameter int SAMP_PER_BIT  = DEF_SAMP_PER_BIT,
  parameter int PKT_LEN       = BOARD_PKT_LEN,
  parameter int CLK_PER_SAMP  = CLK_HZ / BAUD_RATE / SAMP_PER_BIT,
  parameter int WAITING_COUNT = DEF_WAITING_COUNT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  output logic               ready,
  output logic               frame_err,
  output logic [PKT_LEN-1:0] data_out
);

  localparam int IDX_W  = $clog2(SAMP_PER_BIT);
  localparam int BIT_W  = $clog2(PKT_LEN + 1);
  localparam int IDLE_W = $clog2(WAITING_COUNT + 1);
  localparam int M      = SAMP_PER_BIT / 2;

  localparam logic [IDX_W-1:0]  IDX_MID   = IDX_W'(M);
  localparam logic [IDX_W-1:0]  IDX_HI    = IDX_W'(M + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SAMP_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WAITING_COUNT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle level so reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta <= IDLE_LVL;
      rx_s    <= IDLE_LVL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample timebase
  // ---------------------------------------------------------------------------
  link_state_t      state;
  logic             tick;
  logic [IDX_W-1:0] samp_idx;
  logic             vote;
  logic             false_start;
  logic             samp_clear;

  assign false_start = (state == START) && tick && (samp_idx == IDX_MID) &&
                       (rx_s != START_LVL);

  // The timebase is parked at zero whenever no frame is in progress. On the
  // clock that first sees the start level the hold is released, so that clock
  // already counts as the first sample clock of the start bit. This puts the
  // last sample of every bit on the bit's final clock, keeping the M+1
  // sample inside the bit even at SAMP_PER_BIT = 4. The false-start exit also
  // parks it so IDLE is always entered with samp_cnt = samp_idx = 0.
  assign samp_clear = (state == GAP) ||
                      ((state == IDLE) && (rx_s == IDLE_LVL)) ||
                      false_start;

  samp_tick_gen #(
    .CLK_PER_SAMP (CLK_PER_SAMP),
    .SAMP_PER_BIT (SAMP_PER_BIT),
    .IDX_W        (IDX_W)
  ) u_samp_tick_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear    (samp_clear),
    .rx_s     (rx_s),
    .tick     (tick),
    .samp_idx (samp_idx),
    .vote     (vote)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [BIT_W-1:0]   bit_idx;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [PKT_LEN-1:0] shreg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // Resetting into GAP forces a full idle period before the next frame,
      // so a reset in mid-packet cannot lock onto the tail of that packet.
      state     <= GAP;
      idle_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_s == START_LVL) begin
            state <= START;
          end
        end

        START: begin
          if (false_start) begin
            // Line went back high by mid start bit: treat as noise.
            state <= IDLE;
          end else if (tick && (samp_idx == IDX_LAST)) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (tick && (samp_idx == IDX_LAST)) begin
            // Bits arrive LSB first; shifting in from the top leaves the
            // first received bit in shreg[0] after PKT_LEN shifts.
            shreg   <= {vote, shreg[PKT_LEN-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (tick && (samp_idx == IDX_HI)) begin
            if (vote == STOP_LVL) begin
              data_out <= shreg;
              ready    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state    <= GAP;
            idle_cnt <= '0;
          end
        end

        GAP: begin
          // Any low level, including a premature start bit, restarts the
          // idle count; that start bit is simply never acted on.
          if (rx_s != IDLE_LVL) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: begin
          state    <= GAP;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_pkt_rx.sv
// -----------------------------------------------------------------------------
// tb_board_pkt_rx
//
// Directed bench for board_pkt_rx with PKT_LEN=8, SAMP_PER_BIT=4,
// CLK_PER_SAMP=4 (16 clocks per bit), WAITING_COUNT=50.
// The frame-level model: every frame the bench sends either must produce a
// ready (with its payload), must produce a frame_err, or must produce nothing.
// Expected strobes go into a queue with a time window in which they must
// appear (after the stop bit starts, no later than shortly after it ends).
// data_out must always equal the payload of the last accepted frame (0 after
// reset).
// -----------------------------------------------------------------------------
module tb_board_pkt_rx;

  localparam int PKT      = 8;
  localparam int SPB      = 4;
  localparam int CPS      = 4;
  localparam int WAIT_CNT = 50;
  localparam int BIT_CLKS = SPB * CPS;
  localparam int K_READY  = 1;
  localparam int K_FERR   = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx  = 1'b1;
  logic           ready;
  logic           frame_err;
  logic [PKT-1:0] data_out;

  always #5 clk = ~clk;

  board_pkt_rx #(
    .SAMP_PER_BIT  (SPB),
    .PKT_LEN       (PKT),
    .CLK_PER_SAMP  (CPS),
    .WAITING_COUNT (WAIT_CNT)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rx        (rx),
    .ready     (ready),
    .frame_err (frame_err),
    .data_out  (data_out)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_ready  = 0;
  int n_ferr   = 0;

  logic [PKT-1:0] exp_q[$];
  int             kind_q[$];
  int             lo_q[$];
  int             hi_q[$];

  logic [PKT-1:0] model_data = '0;
  logic           rst_q      = 1'b1;
  logic           prev_ready = 1'b0;
  logic           prev_ferr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_q) begin
      model_data = '0;
      exp_q.delete();
      kind_q.delete();
      lo_q.delete();
      hi_q.delete();
      chk("reset_ready_low", {31'b0, ready}, 0);
      chk("reset_frame_err_low", {31'b0, frame_err}, 0);
    end else begin
      if (ready || frame_err) begin
        chk("strobes_exclusive", {31'b0, ready & frame_err}, 0);
        if (ready) n_ready++;
        if (frame_err) n_ferr++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_strobe: ready=%0b frame_err=%0b, required no strobe (cycle %0d)",
                   ready, frame_err, cyc);
        end else begin
          logic [PKT-1:0] d;
          int k, lo, hi;
          d  = exp_q.pop_front();
          k  = kind_q.pop_front();
          lo = lo_q.pop_front();
          hi = hi_q.pop_front();
          chk("strobe_kind", ready ? K_READY : K_FERR, k);
          chk("strobe_in_window", {31'b0, (cyc >= lo) && (cyc <= hi)}, 1);
          if (k == K_READY) begin
            chk("ready_payload", data_out, d);
            model_data = d;
          end
        end
      end
      if (ready) chk("ready_single_cycle", {31'b0, prev_ready}, 0);
      if (frame_err) chk("frame_err_single_cycle", {31'b0, prev_ferr}, 0);
      if (exp_q.size() != 0 && cyc > hi_q[0]) begin
        n_checks++;
        n_errs++;
        $display("FAIL missing_strobe: no strobe by cycle %0d, required kind %0d data %0h",
                 cyc, kind_q[0], exp_q[0]);
        void'(exp_q.pop_front());
        void'(kind_q.pop_front());
        void'(lo_q.pop_front());
        void'(hi_q.pop_front());
      end
    end
    chk("data_out_tracks_model", data_out, model_data);
    prev_ready = ready;
    prev_ferr  = frame_err;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives the first n_clk clocks of a frame. glitch_pos is the frame bit
  // position (0 = start, 1..PKT = data, PKT+1 = stop) whose clocks 5..8 are
  // inverted; those clocks cover the M-1 sample of the bit. kind 0 means
  // the frame must be ignored.
  task automatic send_frame(input logic [PKT-1:0] d, input logic stop_v, input int kind,
                            input int glitch_pos, input int n_clk);
    logic [PKT+1:0] frame;
    frame = {stop_v, d, 1'b0};
    for (int c = 0; c < n_clk; c++) begin
      int   pos;
      int   off;
      logic flip;
      pos  = c / BIT_CLKS;
      off  = c % BIT_CLKS;
      flip = (pos == glitch_pos) && (off >= 5) && (off <= 8);
      @(negedge clk);
      if (c == 0 && kind != 0) begin
        exp_q.push_back(d);
        kind_q.push_back(kind);
        lo_q.push_back(cyc + (PKT + 1) * BIT_CLKS);
        hi_q.push_back(cyc + (PKT + 2) * BIT_CLKS + 4);
      end
      rx = frame[pos] ^ flip;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("por_ready", {31'b0, ready}, 0);
    chk("por_frame_err", {31'b0, frame_err}, 0);
    chk("por_data_out", data_out, 8'h00);

    // Nominal frame.
    idle(60);
    send_frame(8'hA5, 1'b1, K_READY, -1, 160);
    idle(20);
    chk("nominal_data", data_out, 8'hA5);
    chk("nominal_ready_count", n_ready, 1);
    chk("nominal_ferr_count", n_ferr, 0);

    // Bad stop bit: rejected, previous packet kept.
    idle(40);
    send_frame(8'h3C, 1'b0, K_FERR, -1, 160);
    idle(20);
    chk("badstop_data_kept", data_out, 8'hA5);
    chk("badstop_ferr_count", n_ferr, 1);
    chk("badstop_ready_count", n_ready, 1);

    // False start: 6 low clocks, then a valid frame straight from IDLE.
    idle(40);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(20);
    chk("falsestart_no_ready", n_ready, 1);
    chk("falsestart_no_ferr", n_ferr, 1);
    send_frame(8'h3C, 1'b1, K_READY, -1, 160);
    idle(20);
    chk("falsestart_then_data", data_out, 8'h3C);
    chk("falsestart_ready_count", n_ready, 2);

    // Glitch on the M-1 sample of data bit 3 (frame position 4).
    idle(40);
    send_frame(8'hF0, 1'b1, K_READY, 4, 160);
    idle(10);
    chk("glitch_data", data_out, 8'hF0);

    // Gap enforcement: frame 10 clocks after the stop bit is ignored.
    send_frame(8'h11, 1'b1, 0, -1, 160);
    idle(60);
    chk("gap_ignored_data", data_out, 8'hF0);
    chk("gap_ignored_ready_count", n_ready, 3);
    send_frame(8'h11, 1'b1, K_READY, -1, 160);
    idle(20);
    chk("gap_resend_data", data_out, 8'h11);
    chk("gap_resend_ready_count", n_ready, 4);

    // Reset in the middle of data bit 4.
    idle(40);
    send_frame(8'hC3, 1'b1, 0, -1, 5 * BIT_CLKS + 8);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midreset_data", data_out, 8'h00);
    chk("midreset_ready", {31'b0, ready}, 0);
    chk("midreset_frame_err", {31'b0, frame_err}, 0);
    idle(60);
    send_frame(8'h5A, 1'b1, K_READY, -1, 160);
    idle(20);
    chk("postreset_data", data_out, 8'h5A);
    chk("total_ready_count", n_ready, 5);
    chk("total_ferr_count", n_ferr, 1);

    idle(10);
    chk("all_expected_strobes_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
